// File: rtl/swivm_pager_if.sv
// Core/memory bus bundle for swivm_pager.
// slave  : the pager side (takes commands and RAM read data, drives responses and the RAM strobe).
// master : the core/RAM side.
interface swivm_pager_if #(parameter int PA_BITS = 24);
  logic [31:0]        i_addr;
  logic [31:0]        i_wrdata;
  logic [1:0]         i_size;
  logic [3:0]         i_cmd;
  logic               i_validcmd;
  logic               i_usermode;
  logic [31:0]        o_rddata;
  logic               o_rddata_valid;
  logic [3:0]         o_error;
  logic [PA_BITS-3:0] o_mem_addr;
  logic [31:0]        o_mem_wrdata;
  logic [3:0]         o_mem_be;
  logic               o_mem_en;
  logic [31:0]        i_mem_rddata;

  modport slave (
    input  i_addr, i_wrdata, i_size, i_cmd, i_validcmd, i_usermode, i_mem_rddata,
    output o_rddata, o_rddata_valid, o_error, o_mem_addr, o_mem_wrdata, o_mem_be, o_mem_en
  );
  modport master (
    output i_addr, i_wrdata, i_size, i_cmd, i_validcmd, i_usermode, i_mem_rddata,
    input  o_rddata, o_rddata_valid, o_error, o_mem_addr, o_mem_wrdata, o_mem_be, o_mem_en
  );
endinterface

// File: rtl/swivm_pager.sv
// swivm_pager: command responder with direct-mapped TLB and two-level page walker.
// RAM strobes are combinational from the state that issues them, so the 1-cycle RAM returns data
// in the following state. Optional hit/miss counters: define SWIVM_PAGER_STATS_EN.
module swivm_pager #(
  parameter int TLB_ENTRIES = 16,
  parameter int PA_BITS     = 24
) (
  input  logic i_clk,
  input  logic i_reset,
  swivm_pager_if.slave bus
`ifdef SWIVM_PAGER_STATS_EN
  ,
  output logic [31:0] o_tlb_hits,
  output logic [31:0] o_tlb_misses
`endif
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);
  localparam int TAG_W = 20 - IDX_W;
  localparam logic [3:0] C_READ = 4'd1, C_WRITE = 4'd2, C_SETPTB = 4'd3,
                         C_PGON = 4'd4, C_PGOFF = 4'd5, C_FLUSH = 4'd6;

  typedef enum logic [2:0] {S_IDLE, S_XLATE, S_PDE, S_PTE, S_ACCESS} state_t;
  state_t r_state, w_next;

  logic [31:0] r_addr, r_wrdata, r_ptb, r_rddata;
  logic [1:0]  r_size;
  logic [3:0]  r_cmd, r_err, r_error;
  logic        r_user, r_paging, r_valid;
  logic [TLB_ENTRIES-1:0] r_tlb_v, r_tlb_w, r_tlb_u;
  logic [TAG_W-1:0]       r_tlb_tag   [TLB_ENTRIES];
  logic [19:0]            r_tlb_frame [TLB_ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic w_hit, w_is_rw, w_is_ctl, w_wr, w_misal;
  logic [3:0]  w_wr_be, w_err_nxt;
  logic [31:0] w_wr_rep, w_pa, w_lane;
  logic w_do_acc, w_pw, w_pu, w_fill, w_flush, w_setptb, w_pgon, w_pgoff;
  logic w_mem_en;
  logic [PA_BITS-3:0] w_mem_addr;
  logic [3:0]  w_mem_be;
  logic [31:0] w_mem_wrdata;

  assign w_idx    = r_addr[12+IDX_W-1:12];
  assign w_tag    = r_addr[31:12+IDX_W];
  assign w_hit    = r_tlb_v[w_idx] && (r_tlb_tag[w_idx] == w_tag);
  assign w_is_rw  = (r_cmd == C_READ) || (r_cmd == C_WRITE);
  assign w_is_ctl = (r_cmd >= C_SETPTB) && (r_cmd <= C_FLUSH);
  assign w_wr     = (r_cmd == C_WRITE);
  assign w_misal  = (r_size == 2'b11) ? (r_addr[1:0] != 2'b00)
                  : (r_size != 2'b00) ? r_addr[0] : 1'b0;

  // Byte enables and lane-replicated write data for the latched size/offset
  always_comb begin
    w_wr_be  = 4'b1111;
    w_wr_rep = r_wrdata;
    case (r_size)
      2'b00:        begin w_wr_be = 4'b0001 << r_addr[1:0]; w_wr_rep = {4{r_wrdata[7:0]}}; end
      2'b01, 2'b10: begin w_wr_be = r_addr[1] ? 4'b1100 : 4'b0011; w_wr_rep = {2{r_wrdata[15:0]}}; end
      default: ;
    endcase
  end

  // Zero-extended little-endian lane select of the returned RAM word
  always_comb begin
    w_lane = bus.i_mem_rddata;
    case (r_size)
      2'b00: case (r_addr[1:0])
               2'd0: w_lane = {24'b0, bus.i_mem_rddata[7:0]};
               2'd1: w_lane = {24'b0, bus.i_mem_rddata[15:8]};
               2'd2: w_lane = {24'b0, bus.i_mem_rddata[23:16]};
               default: w_lane = {24'b0, bus.i_mem_rddata[31:24]};
             endcase
      2'b01, 2'b10: w_lane = r_addr[1] ? {16'b0, bus.i_mem_rddata[31:16]}
                                       : {16'b0, bus.i_mem_rddata[15:0]};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state, RAM strobes, control-command actions and error selection
  always_comb begin
    w_next = r_state;  w_err_nxt = r_err;
    w_mem_en = 1'b0;   w_mem_addr = '0;  w_mem_be = 4'b0;  w_mem_wrdata = 32'b0;
    w_do_acc = 1'b0;   w_pa = 32'b0;     w_pw = 1'b0;      w_pu = 1'b0;
    w_fill = 1'b0;     w_flush = 1'b0;   w_setptb = 1'b0;  w_pgon = 1'b0;  w_pgoff = 1'b0;
    case (r_state)
      S_IDLE: if (bus.i_validcmd) w_next = S_XLATE;
      S_XLATE: begin
        w_next = S_ACCESS;
        w_err_nxt = 4'd0;
        if (!w_is_rw && !w_is_ctl) w_err_nxt = 4'd5;
        else if (w_is_ctl) begin
          if (r_user) w_err_nxt = 4'd3;
          else case (r_cmd)
            C_SETPTB: w_setptb = 1'b1;
            C_PGON:   w_pgon   = 1'b1;
            C_PGOFF:  w_pgoff  = 1'b1;
            default:  w_flush  = 1'b1;
          endcase
        end
        else if (w_misal) w_err_nxt = 4'd4;
        else if (!r_paging) begin
          w_do_acc = 1'b1; w_pa = r_addr; w_pw = 1'b1; w_pu = 1'b1;
        end
        else if (w_hit) begin
          w_do_acc = 1'b1; w_pa = {r_tlb_frame[w_idx], r_addr[11:0]};
          w_pw = r_tlb_w[w_idx]; w_pu = r_tlb_u[w_idx];
        end
        else begin
          w_mem_en   = 1'b1;
          w_mem_addr = (PA_BITS-2)'((r_ptb + {20'b0, r_addr[31:22], 2'b00}) >> 2);
          w_next     = S_PDE;
        end
      end
      S_PDE: begin
        if (!bus.i_mem_rddata[0]) begin
          w_err_nxt = w_wr ? 4'd2 : 4'd1;
          w_next    = S_ACCESS;
        end else begin
          w_mem_en   = 1'b1;
          w_mem_addr = (PA_BITS-2)'({bus.i_mem_rddata[31:12], r_addr[21:12], 2'b00} >> 2);
          w_next     = S_PTE;
        end
      end
      S_PTE: begin
        w_next = S_ACCESS;
        if (!bus.i_mem_rddata[0]) w_err_nxt = w_wr ? 4'd2 : 4'd1;
        else begin
          w_fill = 1'b1; w_do_acc = 1'b1;
          w_pa = {bus.i_mem_rddata[31:12], r_addr[11:0]};
          w_pw = bus.i_mem_rddata[1]; w_pu = bus.i_mem_rddata[2];
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Permission check gates the data strobe for every translated access
    if (w_do_acc) begin
      if (r_user && !w_pu)  w_err_nxt = 4'd3;
      else if (w_wr && !w_pw) w_err_nxt = 4'd2;
      else begin
        w_mem_en   = 1'b1;
        w_mem_addr = (PA_BITS-2)'(w_pa >> 2);
        if (w_wr) begin w_mem_be = w_wr_be; w_mem_wrdata = w_wr_rep; end
      end
    end
  end

  // Command latch, MMU control state, TLB valids and the registered response
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr <= '0; r_wrdata <= '0; r_size <= '0; r_cmd <= '0; r_user <= 1'b0;
      r_paging <= 1'b0; r_ptb <= '0; r_tlb_v <= '0; r_err <= '0;
      r_valid <= 1'b0; r_rddata <= '0; r_error <= '0;
    end else begin
      if (r_state == S_IDLE && bus.i_validcmd) begin
        r_addr <= bus.i_addr; r_wrdata <= bus.i_wrdata; r_size <= bus.i_size;
        r_cmd <= bus.i_cmd;   r_user <= bus.i_usermode;
      end
      r_err <= w_err_nxt;
      if (w_setptb) r_ptb <= r_wrdata;
      if (w_pgon)   r_paging <= 1'b1;
      if (w_pgoff)  r_paging <= 1'b0;
      if (w_flush)  r_tlb_v <= '0;
      if (w_fill)   r_tlb_v[w_idx] <= 1'b1;
      r_valid <= 1'b0;
      if (r_state == S_ACCESS) begin
        r_valid  <= 1'b1;
        r_error  <= r_err;
        r_rddata <= (r_cmd == C_READ && r_err == 4'd0) ? w_lane : 32'b0;
      end
    end
  end

  // TLB payload written on fill; validity lives in r_tlb_v
  always_ff @(posedge i_clk) begin
    if (w_fill) begin
      r_tlb_tag[w_idx]   <= w_tag;
      r_tlb_frame[w_idx] <= bus.i_mem_rddata[31:12];
      r_tlb_w[w_idx]     <= bus.i_mem_rddata[1];
      r_tlb_u[w_idx]     <= bus.i_mem_rddata[2];
    end
  end

`ifdef SWIVM_PAGER_STATS_EN
  logic w_xl_rw;
  assign w_xl_rw = (r_state == S_XLATE) && w_is_rw && !w_misal && r_paging;
  // Saturating hit/miss counters over translated accesses
  always_ff @(posedge i_clk) begin
    if (i_reset || w_flush) begin
      o_tlb_hits <= '0; o_tlb_misses <= '0;
    end else if (w_xl_rw) begin
      if (w_hit && o_tlb_hits != 32'hFFFF_FFFF)    o_tlb_hits   <= o_tlb_hits + 32'd1;
      if (!w_hit && o_tlb_misses != 32'hFFFF_FFFF) o_tlb_misses <= o_tlb_misses + 32'd1;
    end
  end
`endif

  assign bus.o_rddata       = r_rddata;
  assign bus.o_rddata_valid = r_valid;
  assign bus.o_error        = r_error;
  assign bus.o_mem_en       = w_mem_en;
  assign bus.o_mem_addr     = w_mem_addr;
  assign bus.o_mem_be       = w_mem_be;
  assign bus.o_mem_wrdata   = w_mem_wrdata;
endmodule
